// File: rtl/tthbif_uart_regfile.sv
// tthbif_uart_regfile: UART command decoder and control register file for
// the TT-HBIF link. Decodes single-byte reads and two-byte writes arriving
// from the UART receiver and drives the four tap-select buses of the core.
//
// Optional feature: define TTHBIF_RF_WRITE_ACK_EN to return 8'h06 after every
// completed write. Without it, writes produce no tx traffic.
//
// Ports:
//   clk_i, rst_ni          core clock, asynchronous active-low reset
//   en_i                   block enable (low: FSM idles, registers hold)
//   rx_data_valid_i/_i     received byte strobe and data
//   tx_data_ready_i        transmitter can take a byte
//   tx_data_valid_o/_o     response byte handshake
//   *_tap_sel_o            TAPSEL register fields to the core
module tthbif_uart_regfile #(
    parameter int unsigned TIMEOUT_CLKS = 65536,
    parameter logic [7:0]  ID_VALUE     = 8'hB1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       rx_data_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_data_ready_i,
    output logic       tx_data_valid_o,
    output logic [7:0] tx_data_o,
    output logic [1:0] rx_flop_tap_sel_o,
    output logic [1:0] rx_comb_tap_sel_o,
    output logic [1:0] tx_flop_tap_sel_o,
    output logic [1:0] tx_comb_tap_sel_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
`ifdef TTHBIF_RF_WRITE_ACK_EN
    localparam logic [7:0] ACK_BYTE = 8'h06;
`endif

    localparam logic [3:0] ADDR_STATUS  = 4'h0;
    localparam logic [3:0] ADDR_TAPSEL  = 4'h1;
    localparam logic [3:0] ADDR_SCRATCH = 4'h2;
    localparam logic [3:0] ADDR_ID      = 4'h3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       status_q, status_d;
    logic [7:0]       tapsel_q, tapsel_d;
    logic [7:0]       scratch_q, scratch_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       rd_data_c;
    logic [1:0]       status_clr_c;
    logic             set_ovr_c, set_to_c;

    // Read mux addressed directly by the incoming command byte
    always_comb begin
        rd_data_c = 8'h00;
        case (rx_data_i[3:0])
            ADDR_STATUS:  rd_data_c = {6'b0, status_q};
            ADDR_TAPSEL:  rd_data_c = tapsel_q;
            ADDR_SCRATCH: rd_data_c = scratch_q;
            ADDR_ID:      rd_data_c = ID_VALUE;
            default:      rd_data_c = 8'h00;
        endcase
    end

    // Next-state, register update and response logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        tapsel_d     = tapsel_q;
        scratch_d    = scratch_q;
        tx_data_d    = tx_data_q;
        status_clr_c = 2'b00;
        set_ovr_c    = 1'b0;
        set_to_c     = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Reserved bits [6:4] set: byte silently discarded
                    if (rx_data_valid_i && (rx_data_i[6:4] == 3'b000)) begin
                        if (rx_data_i[7]) begin
                            state_d = WDATA;
                            addr_d  = rx_data_i[3:0];
                            cnt_d   = '0;
                        end else begin
                            state_d   = RESP;
                            tx_data_d = rd_data_c;
                        end
                    end
                end
                WDATA: begin
                    // A byte in the expiry cycle still completes the write
                    if (rx_data_valid_i) begin
                        case (addr_q)
                            ADDR_STATUS:  status_clr_c = rx_data_i[1:0];
                            ADDR_TAPSEL:  tapsel_d     = rx_data_i;
                            ADDR_SCRATCH: scratch_d    = rx_data_i;
                            default:      ;
                        endcase
                        cnt_d = '0;
`ifdef TTHBIF_RF_WRITE_ACK_EN
                        state_d   = RESP;
                        tx_data_d = ACK_BYTE;
`else
                        state_d   = IDLE;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        set_to_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rx_data_valid_i) set_ovr_c = 1'b1;
                    if (tx_data_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Hardware set beats a simultaneous W1C
        status_d   = (status_q & ~status_clr_c) | {set_to_c, set_ovr_c};
        tx_valid_d = (state_d == RESP);
    end

    // State and register file
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= 4'h0;
            cnt_q      <= '0;
            status_q   <= 2'b00;
            tapsel_q   <= 8'hFF;
            scratch_q  <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            tapsel_q   <= tapsel_d;
            scratch_q  <= scratch_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data_valid_o   = tx_valid_q;
    assign tx_data_o         = tx_data_q;
    assign rx_flop_tap_sel_o = tapsel_q[1:0];
    assign rx_comb_tap_sel_o = tapsel_q[3:2];
    assign tx_flop_tap_sel_o = tapsel_q[5:4];
    assign tx_comb_tap_sel_o = tapsel_q[7:6];

endmodule

// File: tb/tb_tthbif_uart_regfile.sv
// Directed testbench for tthbif_uart_regfile with a response scoreboard.
module tb_tthbif_uart_regfile;

    localparam int unsigned TO_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       rx_data_valid_i;
    logic [7:0] rx_data_i;
    logic       tx_data_ready_i;
    logic       tx_data_valid_o;
    logic [7:0] tx_data_o;
    logic [1:0] rx_flop_tap_sel_o;
    logic [1:0] rx_comb_tap_sel_o;
    logic [1:0] tx_flop_tap_sel_o;
    logic [1:0] tx_comb_tap_sel_o;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    tthbif_uart_regfile #(
        .TIMEOUT_CLKS(TO_CLKS),
        .ID_VALUE    (8'hB1)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .rx_data_valid_i  (rx_data_valid_i),
        .rx_data_i        (rx_data_i),
        .tx_data_ready_i  (tx_data_ready_i),
        .tx_data_valid_o  (tx_data_valid_o),
        .tx_data_o        (tx_data_o),
        .rx_flop_tap_sel_o(rx_flop_tap_sel_o),
        .rx_comb_tap_sel_o(rx_comb_tap_sel_o),
        .tx_flop_tap_sel_o(tx_flop_tap_sel_o),
        .tx_comb_tap_sel_o(tx_comb_tap_sel_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] taps();
        return {tx_comb_tap_sel_o, tx_flop_tap_sel_o, rx_comb_tap_sel_o, rx_flop_tap_sel_o};
    endfunction

    // One-cycle rx strobe; returns in the middle of the following cycle
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_valid_i = 1'b1;
        rx_data_i       = b;
        @(negedge clk);
        rx_data_valid_i = 1'b0;
        rx_data_i       = 8'h00;
    endtask

    // Pop the expected byte, wait (bounded) for valid, compare, complete handshake
    task automatic wait_resp(input string tag);
        logic [7:0] exp;
        int n;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        exp = sb.pop_front();
        n = 0;
        while (tx_data_valid_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {7'b0, tx_data_valid_o}, 8'h01);
        check({tag, "_data"}, tx_data_o, exp);
        tx_data_ready_i = 1'b1;
        @(negedge clk);
        tx_data_ready_i = 1'b0;
        check({tag, "_drop"}, {7'b0, tx_data_valid_o}, 8'h00);
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [7:0] exp, input string tag);
        sb.push_back(exp);
        send_byte({4'h0, addr});
        check({tag, "_lat"}, {7'b0, tx_data_valid_o}, 8'h01);
        wait_resp(tag);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
        send_byte({4'h8, addr});
        send_byte(data);
`ifdef TTHBIF_RF_WRITE_ACK_EN
        sb.push_back(8'h06);
        wait_resp("ack");
`endif
    endtask

    initial begin
        rst_ni          = 1'b1;
        en_i            = 1'b1;
        rx_data_valid_i = 1'b0;
        rx_data_i       = 8'h00;
        tx_data_ready_i = 1'b0;
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_valid", {7'b0, tx_data_valid_o}, 8'h00);
        check("rst_data", tx_data_o, 8'h00);
        check("rst_taps", taps(), 8'hFF);
        rst_ni = 1'b1;
        @(negedge clk);

        do_read(4'h1, 8'hFF, "rd_tapsel_rst");
        do_read(4'h3, 8'hB1, "rd_id");
        check("taps_idle", taps(), 8'hFF);

        // TAPSEL write decodes onto the four buses
        do_write(4'h1, 8'h1B);
        check("rx_flop", {6'b0, rx_flop_tap_sel_o}, 8'h03);
        check("rx_comb", {6'b0, rx_comb_tap_sel_o}, 8'h02);
        check("tx_flop", {6'b0, tx_flop_tap_sel_o}, 8'h01);
        check("tx_comb", {6'b0, tx_comb_tap_sel_o}, 8'h00);
        do_read(4'h1, 8'h1B, "rd_tapsel");

        // Data byte in the expiry cycle is accepted
        send_byte(8'h82);
        repeat (TO_CLKS - 2) @(negedge clk);
        send_byte(8'h5A);
`ifdef TTHBIF_RF_WRITE_ACK_EN
        sb.push_back(8'h06);
        wait_resp("ack_edge");
`endif
        do_read(4'h0, 8'h00, "rd_status_edge");
        do_read(4'h2, 8'h5A, "rd_scratch_edge");

        // Timeout with no data
        send_byte(8'h82);
        repeat (TO_CLKS + 4) @(negedge clk);
        do_read(4'h0, 8'h02, "rd_status_to");
        do_read(4'h2, 8'h5A, "rd_scratch_to");
        do_write(4'h0, 8'h02);
        do_read(4'h0, 8'h00, "rd_status_clr");

        // Backpressure with an extra byte -> overrun, response held
        sb.push_back(8'h5A);
        send_byte(8'h02);
        for (int i = 0; i < 50; i++) begin
            rx_data_valid_i = (i == 10);
            rx_data_i       = (i == 10) ? 8'h01 : 8'h00;
            check("hold_valid", {7'b0, tx_data_valid_o}, 8'h01);
            check("hold_data", tx_data_o, 8'h5A);
            @(negedge clk);
        end
        rx_data_valid_i = 1'b0;
        wait_resp("rd_held");
        do_read(4'h0, 8'h01, "rd_status_ovr");
        do_write(4'h0, 8'h01);
        do_read(4'h0, 8'h00, "rd_status_clr2");

        // Reserved bits: discarded, no response, FSM stays idle
        send_byte(8'h93);
        repeat (4) begin
            check("rsvd_noresp", {7'b0, tx_data_valid_o}, 8'h00);
            @(negedge clk);
        end
        do_read(4'hA, 8'h00, "rd_unmapped");

        // Ignored writes
        do_write(4'h3, 8'h55);
        do_read(4'h3, 8'hB1, "rd_id_wr");
        do_write(4'hA, 8'h77);
        do_read(4'hA, 8'h00, "rd_unmapped_wr");

        // Disabled: bytes ignored, no flags
        en_i = 1'b0;
        send_byte(8'h01);
        send_byte(8'h81);
        send_byte(8'h00);
        repeat (3) begin
            check("dis_noresp", {7'b0, tx_data_valid_o}, 8'h00);
            @(negedge clk);
        end
        en_i = 1'b1;
        @(negedge clk);
        do_read(4'h0, 8'h00, "rd_status_dis");
        do_read(4'h1, 8'h1B, "rd_tapsel_dis");

        // Asynchronous reset while a response is pending
        send_byte(8'h01);
        check("pre_rst_valid", {7'b0, tx_data_valid_o}, 8'h01);
        #2 rst_ni = 1'b0;
        #1;
        check("async_valid", {7'b0, tx_data_valid_o}, 8'h00);
        check("async_taps", taps(), 8'hFF);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        do_read(4'h1, 8'hFF, "rd_tapsel_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tthbif_uart_regfile.md
# tthbif_uart_regfile

UART command decoder and control register file for the TT-HBIF link. It consumes bytes from the UART receiver, decodes single-byte read and two-byte write commands, and drives the four tap-select configuration buses of the tthbif core. Read data and optional write acknowledges are returned to the UART transmitter over a valid/ready handshake. This replaces the fixed 2'b11 tap selects and the UART loopback in the top level.

## Interface
- TIMEOUT_CLKS, 65536: idle clocks allowed between a write command byte and its data byte; minimum 2
- ID_VALUE, 8'hB1: constant returned by the ID register
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  block enable; low forces FSM to IDLE, registers hold
- rx_data_valid_i  in  1  one-cycle strobe, UART byte received
- rx_data_i  in  8  received byte, valid with strobe
- tx_data_ready_i  in  1  UART transmitter can accept a byte
- tx_data_valid_o  out  1  response byte valid; reset 0
- tx_data_o  out  8  response byte; reset 8'h00
- rx_flop_tap_sel_o  out  2  TAPSEL[1:0]; reset 2'b11
- rx_comb_tap_sel_o  out  2  TAPSEL[3:2]; reset 2'b11
- tx_flop_tap_sel_o  out  2  TAPSEL[5:4]; reset 2'b11
- tx_comb_tap_sel_o  out  2  TAPSEL[7:6]; reset 2'b11

## Operation
- Command byte: bit7 = 1 write / 0 read; bits[6:4] must be 0, otherwise byte is discarded; bits[3:0] = address.
- Register map:
  - 0x0 STATUS: bit0 overrun, bit1 timeout; both sticky, write-1-to-clear; other bits read 0; reset 0x00.
  - 0x1 TAPSEL: R/W 8 bits; reset 0xFF.
  - 0x2 SCRATCH: R/W 8 bits; reset 0x00.
  - 0x3 ID: read-only ID_VALUE; writes ignored.
  - 0x4-0xF: read 0x00; writes ignored.
- FSM states IDLE, WDATA, RESP; reset state IDLE.
  - IDLE + valid read command -> RESP; tx_data_o loaded with register value.
  - IDLE + valid write command -> WDATA; address latched, timeout counter cleared.
  - WDATA + rx byte -> register written; next state IDLE (RESP when ack is compiled in).
  - WDATA + counter reaching TIMEOUT_CLKS-1 with no byte -> IDLE; STATUS.timeout set.
  - RESP + tx_data_ready_i -> IDLE.
- Any rx byte arriving in RESP is dropped and STATUS.overrun is set.
- If a hardware set and a W1C write hit the same STATUS bit in one cycle, the set wins.
- en_i low: state forced to IDLE; tx_data_valid_o = 0; rx bytes ignored without setting flags; timeout counter held at 0.

## Timing
- Read command strobe in cycle N: tx_data_valid_o = 1 with data from cycle N+1. Data is the register value at cycle N.
- tx_data_valid_o and tx_data_o are held stable until a cycle in which tx_data_ready_i = 1. Transfer occurs in that cycle. tx_data_valid_o = 0 the next cycle.
- Write data strobe in cycle M: register and tap-select outputs update at M+1.
- Timeout counter increments once per enabled cycle in WDATA. Counter width is $clog2(TIMEOUT_CLKS).
- A data byte arriving in the expiry cycle is accepted: the write completes and no timeout flag is set.
- Minimum command spacing is one clock. Back-to-back read commands while in RESP overrun by design.
- Asynchronous reset mid-operation: all outputs, registers, flags and FSM return to reset values immediately. A pending response is lost.

## Configuration
- TTHBIF_RF_WRITE_ACK_EN defined: each completed write, including ignored addresses, enters RESP and returns byte 8'h06. It uses the same handshake and latency as a read, counted from the data strobe.
- Not defined: writes produce no tx traffic, and WDATA returns directly to IDLE.

## Test plan
- Reset, then read 0x01 and read 0x03 -> responses 0xFF and 0xB1; tap-select outputs all 2'b11.
- Write 0x81, 0x1B -> rx_flop=2'b11, rx_comb=2'b10, tx_flop=2'b01, tx_comb=2'b00 one cycle after the data strobe. Read 0x01 -> 0x1B. With ACK_EN, 0x06 is sent before the read response.
- Write command 0x82 then no data for TIMEOUT_CLKS (set to 16) -> FSM idle; read 0x00 -> 0x02. Write 0x80, 0x02 -> subsequent read 0x00 returns 0x00.
- Hold tx_data_ready_i low 50 cycles after read 0x02; send an extra byte meanwhile -> response stable throughout; STATUS then reads 0x01.
- Command 0x93 (reserved bits) -> no response, no state change; read 0x0A -> 0x00.
- Assert rst_ni low while tx_data_valid_o is high -> valid drops asynchronously; TAPSEL reads 0xFF after release.
